traffic_input_cond: RTL

Input conditioning stage directly upstream of the traffic-light controller FSM. It synchronises and debounces the raw road sensors (A, B) and the parade/release push-buttons. It outputs the level signals traffic_a and traffic_b, stretched across car gaps, plus single-cycle mode_p and mode_r pulses. All outputs come straight from flops and connect 1:1 to the controller's i_traffic_a, i_traffic_b, i_mode_p and i_mode_r.

---
 rtl/traffic_input_cond_pkg.sv | 26 ++
 rtl/traffic_input_cond_if.sv | 24 ++
 rtl/traffic_input_cond_debounce.sv | 46 ++++
 rtl/traffic_input_cond.sv | 108 ++++++++++
 4 files changed

// File: rtl/traffic_input_cond_pkg.sv
// traffic_input_cond shared definitions: parameter defaults,
// raw input polarity, channel indices and the clog2 width helper.
package traffic_input_cond_pkg;

  localparam int DEB_CYC_DEF  = 4;
  localparam int HOLD_CYC_DEF = 8;
  localparam int LOCK_CYC_DEF = 16;

  localparam logic SENSOR_ACTIVE = 1'b1;
  localparam logic BTN_ACTIVE    = 1'b1;

  localparam int CH_A = 0;
  localparam int CH_B = 1;
  localparam int CH_P = 2;
  localparam int CH_R = 3;

  // Never returns 0 so zero-valued parameters still give a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/traffic_input_cond_if.sv
// Raw sensor/button inputs and conditioned controller-facing outputs.
// master: drives raw inputs; slave: the conditioning stage.
interface traffic_input_cond_if;

  logic i_sensor_a;
  logic i_sensor_b;
  logic i_btn_p;
  logic i_btn_r;
  logic o_traffic_a;
  logic o_traffic_b;
  logic o_mode_p;
  logic o_mode_r;

  modport master (
    output i_sensor_a, i_sensor_b, i_btn_p, i_btn_r,
    input  o_traffic_a, o_traffic_b, o_mode_p, o_mode_r
  );

  modport slave (
    input  i_sensor_a, i_sensor_b, i_btn_p, i_btn_r,
    output o_traffic_a, o_traffic_b, o_mode_p, o_mode_r
  );

endinterface

// File: rtl/traffic_input_cond_debounce.sv
// input_debounce: 2-flop synchroniser plus run-length debounce.
// Ports: clk, rst_n, raw (async, active-high), d (debounced), rise.
module input_debounce
  import traffic_input_cond_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic d,
  output logic rise
);

  localparam int CW = clog2(DEB_CYC + 1);

  logic          s1;
  logic          s2;
  logic          d_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      d   <= 1'b0;
      d_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      d_q <= d;
      if (s2 == d) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYC - 1)) begin
        d   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/traffic_input_cond.sv
// traffic_input_cond: debounce sensors/buttons, stretch traffic, pulse modes.
// Ports: i_clk, i_rstn, bus (slave). Option: COND_LOCKOUT_EN.
module traffic_input_cond
  import traffic_input_cond_pkg::*;
#(
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF
`ifdef COND_LOCKOUT_EN
  ,
  parameter int LOCK_CYC = LOCK_CYC_DEF
`endif
) (
  input  logic i_clk,
  input  logic i_rstn,
  traffic_input_cond_if.slave bus
);

  localparam int HW = clog2(HOLD_CYC + 1);

  logic [3:0]    raw;
  logic [3:0]    d;
  logic [3:0]    rise;
  logic [1:0]    d_prev;
  logic [HW-1:0] hold    [2];
  logic [HW-1:0] hold_nx [2];
  logic [1:0]    traffic_q;
  logic          mode_p_q;
  logic          mode_r_q;
  logic          lock;
  logic          go_p;
  logic          go_r;

  assign raw[CH_A] = bus.i_sensor_a ~^ SENSOR_ACTIVE;
  assign raw[CH_B] = bus.i_sensor_b ~^ SENSOR_ACTIVE;
  assign raw[CH_P] = bus.i_btn_p ~^ BTN_ACTIVE;
  assign raw[CH_R] = bus.i_btn_r ~^ BTN_ACTIVE;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    input_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (i_clk),
      .rst_n(i_rstn),
      .raw  (raw[g]),
      .d    (d[g]),
      .rise (rise[g])
    );
  end

  // Hold reloads on the cycle d is first seen low after being high.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hold_nx[i] = '0;
      if (d[i])
        hold_nx[i] = '0;
      else if (d_prev[i])
        hold_nx[i] = HW'(HOLD_CYC);
      else if (hold[i] != '0)
        hold_nx[i] = hold[i] - HW'(1);
    end
  end

  // Simultaneous requests cancel: the controller must never see both.
  assign go_p = rise[CH_P] & ~rise[CH_R] & ~lock;
  assign go_r = rise[CH_R] & ~rise[CH_P] & ~lock;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      d_prev    <= '0;
      hold[0]   <= '0;
      hold[1]   <= '0;
      traffic_q <= '0;
      mode_p_q  <= 1'b0;
      mode_r_q  <= 1'b0;
    end else begin
      d_prev       <= d[1:0];
      hold[0]      <= hold_nx[0];
      hold[1]      <= hold_nx[1];
      traffic_q[0] <= d[0] | (hold_nx[0] != '0);
      traffic_q[1] <= d[1] | (hold_nx[1] != '0);
      mode_p_q     <= go_p;
      mode_r_q     <= go_r;
    end
  end

`ifdef COND_LOCKOUT_EN
  localparam int LW = clog2(LOCK_CYC + 1);

  logic [LW-1:0] lock_cnt;

  assign lock = (lock_cnt != '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      lock_cnt <= '0;
    else if (go_p | go_r)
      lock_cnt <= LW'(LOCK_CYC);
    else if (lock)
      lock_cnt <= lock_cnt - LW'(1);
  end
`else
  assign lock = 1'b0;
`endif

  assign bus.o_traffic_a = traffic_q[0];
  assign bus.o_traffic_b = traffic_q[1];
  assign bus.o_mode_p    = mode_p_q;
  assign bus.o_mode_r    = mode_r_q;

endmodule
